// File: rtl/fu_mem_arbiter_pkg.sv
// Shared types for the FU-to-data-memory arbiter.
package fu_mem_arbiter_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } MEM_CMD;

  typedef struct packed {
    MEM_CMD            cmd;
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   data;
  } FU_MEM_PACKET;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } MEM_ARB_STATE;

endpackage

// File: rtl/fu_mem_arbiter_rr_picker.sv
// Combinational request picker: fixed lowest-index priority, or
// round-robin starting the search at rr_ptr and wrapping.
module rr_picker
  #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned RR_MODE = 0
  )
  (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] idx,
    output logic                       valid
  );

  localparam int unsigned IW = $clog2(NUM_REQ);

  // Scan NUM_REQ positions from the start index; first asserted request wins.
  always_comb begin
    int unsigned     base;
    logic [IW-1:0]   j;
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    base  = (RR_MODE != 0) ? 32'(rr_ptr) : 32'd0;
    j     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      j = IW'((base + k) % NUM_REQ);
      if (!valid && req[j]) begin
        valid    = 1'b1;
        idx      = j;
        grant[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fu_mem_arbiter.sv
// Arbitrates NUM_REQ memory FUs onto the single data-memory port, tracks the
// one in-flight access and returns its data to the owning FU.
module fu_mem_arbiter
  import fu_mem_arbiter_pkg::*;
  #(
    parameter int unsigned NUM_REQ     = 2,
    parameter int unsigned RR_MODE     = 0,
    parameter int unsigned MEM_LATENCY = 1
  )
  (
    input  logic                clock,
    input  logic                reset,
    input  logic                squash_valid,
    input  logic [NUM_REQ-1:0]  mem_req,
    input  FU_MEM_PACKET        fu_mem_packets [NUM_REQ],
    input  logic [XLEN-1:0]     Dmem2proc_data,
    output logic [NUM_REQ-1:0]  mem_ack,
    output FU_MEM_PACKET        fu_mem_packet,
    output logic [NUM_REQ-1:0]  resp_valid,
    output logic [XLEN-1:0]     resp_data,
    output logic                busy
  );

  localparam int unsigned     IW       = $clog2(NUM_REQ);
  localparam int unsigned     LW       = $clog2(MEM_LATENCY + 1);
  localparam logic [LW-1:0]   LAT_MAX  = LW'(MEM_LATENCY);
  localparam logic [IW-1:0]   LAST_IDX = IW'(NUM_REQ - 1);

  MEM_ARB_STATE   state;
  logic [IW-1:0]  owner;
  logic [IW-1:0]  rr_ptr;
  logic [LW-1:0]  lat_cnt;

  logic [NUM_REQ-1:0] pick_grant;
  logic [IW-1:0]      pick_idx;
  logic               pick_valid;
  logic               done;
  logic               issue_ok;

  rr_picker #(.NUM_REQ(NUM_REQ), .RR_MODE(RR_MODE)) u_picker (
    .req    (mem_req),
    .rr_ptr (rr_ptr),
    .grant  (pick_grant),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  // Completion and issue qualification; squash blocks both response and grant.
  always_comb begin
    done     = (state == BUSY) && (lat_cnt == LAT_MAX);
    issue_ok = ((state == IDLE) || done) && !squash_valid && pick_valid;
  end

  // Output muxing: grant/packet on issue, response to owner on completion.
  always_comb begin
    mem_ack       = '0;
    fu_mem_packet = '0;
    resp_valid    = '0;
    resp_data     = '0;
    busy          = (state != IDLE);
    if (issue_ok) begin
      mem_ack       = pick_grant;
      fu_mem_packet = fu_mem_packets[pick_idx];
    end
    if (done && !squash_valid) begin
      resp_valid[owner] = 1'b1;
      resp_data         = Dmem2proc_data;
    end
  end

  // FSM: a grant from IDLE or a completing BUSY restarts the latency count;
  // otherwise BUSY/DRAIN count out the latency, squash diverting BUSY to DRAIN.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      owner   <= '0;
      lat_cnt <= '0;
      rr_ptr  <= '0;
    end else if (issue_ok) begin
      state   <= BUSY;
      owner   <= pick_idx;
      lat_cnt <= LW'(1);
      rr_ptr  <= (pick_idx == LAST_IDX) ? '0 : pick_idx + IW'(1);
    end else begin
      case (state)
        BUSY: begin
          if (done) begin
            state   <= IDLE;
            lat_cnt <= '0;
          end else begin
            if (squash_valid) state <= DRAIN;
            lat_cnt <= lat_cnt + LW'(1);
          end
        end
        DRAIN: begin
          if (lat_cnt == LAT_MAX) begin
            state   <= IDLE;
            lat_cnt <= '0;
          end else begin
            lat_cnt <= lat_cnt + LW'(1);
          end
        end
        default: begin
          state   <= IDLE;
          lat_cnt <= '0;
        end
      endcase
    end
  end

endmodule
